// File: rtl/src_loader.sv
// -----------------------------------------------------------------------------
// src_loader
//   Write-side front end of src_buf. Accepts DATA_W-bit beats from the DMA
//   stream and writes them into one of two ping-pong banks of src_buf. The
//   bank is the top address bit. Each bank is tracked as EMPTY / FILLING /
//   FULL, so the exec side only reads a completed bank. Exec hands a bank
//   back with a one-cycle release pulse.
//
// Ports
//   clk, rst          clock (posedge), asynchronous active-high reset
//   s_valid/s_ready   stream handshake; a beat is accepted when both are high
//   s_data, s_last    beat payload; s_last closes the current bank
//   src_v/src_a/src_d write strobe, {bank, word ptr} and data to src_buf
//   bank_full         bit b set while bank b is FULL
//   bank_len0/1       number of words written into bank 0/1 at its last close
//   bank_release      per-bank pulse from exec: FULL bank -> EMPTY
//   trunc             sticky flag: a bank filled up without s_last
// -----------------------------------------------------------------------------
module src_loader #(
  parameter int DEPTH_LOG2 = 9,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  output logic                  src_v,
  output logic [DEPTH_LOG2:0]   src_a,
  output logic [DATA_W-1:0]     src_d,
  output logic [1:0]            bank_full,
  output logic [DEPTH_LOG2:0]   bank_len0,
  output logic [DEPTH_LOG2:0]   bank_len1,
  input  logic [1:0]            bank_release,
  output logic                  trunc
);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2
  } bank_st_t;

  localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LEN_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  bank_st_t                bank_st_r  [0:1];
  bank_st_t                bank_nxt_s [0:1];
  logic                    wr_bank_r;
  logic                    wr_bank_nxt_s;
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [DEPTH_LOG2-1:0]   wr_ptr_nxt_s;
  logic [1:0]              sel_s;
  logic                    accept_s;
  logic                    at_max_s;
  logic                    close_s;
  logic                    s_ready_nxt_s;
  logic [DEPTH_LOG2:0]     len_s;

  // Handshake decode and close detection for the beat on the bus this cycle.
  always_comb begin
    accept_s = s_valid & s_ready;
    at_max_s = (wr_ptr_r == PTR_MAX);
    close_s  = accept_s & (s_last | at_max_s);
    sel_s    = wr_bank_r ? 2'b10 : 2'b01;
    len_s    = {1'b0, wr_ptr_r} + LEN_ONE;
  end

  // Next-state logic for both bank FSMs, write pointer and ready flag.
  always_comb begin
    bank_nxt_s[0] = bank_st_r[0];
    bank_nxt_s[1] = bank_st_r[1];
    for (int b = 0; b < 2; b++) begin
      case (bank_st_r[b])
        B_EMPTY: begin
          if (accept_s && sel_s[b]) begin
            bank_nxt_s[b] = close_s ? B_FULL : B_FILLING;
          end else begin
            bank_nxt_s[b] = B_EMPTY;
          end
        end
        // A release seen while FILLING is deliberately dropped, even when it
        // coincides with the closing beat: the bank still ends FULL.
        B_FILLING: begin
          if (close_s && sel_s[b]) begin
            bank_nxt_s[b] = B_FULL;
          end else begin
            bank_nxt_s[b] = B_FILLING;
          end
        end
        B_FULL: begin
          if (bank_release[b]) begin
            bank_nxt_s[b] = B_EMPTY;
          end else begin
            bank_nxt_s[b] = B_FULL;
          end
        end
        default: begin
          bank_nxt_s[b] = B_EMPTY;
        end
      endcase
    end

    if (close_s) begin
      wr_bank_nxt_s = ~wr_bank_r;
      wr_ptr_nxt_s  = '0;
    end else if (accept_s) begin
      wr_bank_nxt_s = wr_bank_r;
      wr_ptr_nxt_s  = wr_ptr_r + PTR_ONE;
    end else begin
      wr_bank_nxt_s = wr_bank_r;
      wr_ptr_nxt_s  = wr_ptr_r;
    end

    // Ready looks at the bank we will be writing next cycle, so a close into
    // an already-full partner drops ready before another beat can slip in.
    s_ready_nxt_s = (bank_nxt_s[wr_bank_nxt_s] != B_FULL);
  end

  // State, pointer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st_r[0] <= B_EMPTY;
      bank_st_r[1] <= B_EMPTY;
      wr_bank_r    <= 1'b0;
      wr_ptr_r     <= '0;
      s_ready      <= 1'b0;
      src_v        <= 1'b0;
      src_a        <= '0;
      src_d        <= '0;
      bank_full    <= 2'b00;
      bank_len0    <= '0;
      bank_len1    <= '0;
      trunc        <= 1'b0;
    end else begin
      bank_st_r[0] <= bank_nxt_s[0];
      bank_st_r[1] <= bank_nxt_s[1];
      wr_bank_r    <= wr_bank_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      s_ready      <= s_ready_nxt_s;
      src_v        <= accept_s;
      bank_full    <= {bank_nxt_s[1] == B_FULL, bank_nxt_s[0] == B_FULL};
      if (accept_s) begin
        src_a <= {wr_bank_r, wr_ptr_r};
        src_d <= s_data;
      end else begin
        src_a <= src_a;
        src_d <= src_d;
      end
      if (close_s && !wr_bank_r) begin
        bank_len0 <= len_s;
      end else begin
        bank_len0 <= bank_len0;
      end
      if (close_s && wr_bank_r) begin
        bank_len1 <= len_s;
      end else begin
        bank_len1 <= bank_len1;
      end
      // Filling the last word without s_last means the block was cut short.
      if (accept_s && at_max_s && !s_last) begin
        trunc <= 1'b1;
      end else begin
        trunc <= trunc;
      end
    end
  end

endmodule
